// File: rtl/sdram_loader_pkg.sv
// rtl/sdram_loader_pkg.sv - shared types, byte-mask constants and routing helpers for the ROM loader
package sdram_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        ISSUE,
        WAIT_ACK,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        PSEL_NONE,
        PSEL_1,
        PSEL_2
    } psel_t;

    localparam logic [1:0] DS_LO   = 2'b01;
    localparam logic [1:0] DS_HI   = 2'b10;
    localparam logic [1:0] DS_BOTH = 2'b11;

    // Region decode on an even byte address; the limit is computed one bit wider so it cannot wrap.
    function automatic psel_t route_sel(input logic [24:0] e, input logic [24:0] base,
                                        input logic [24:0] size);
        logic [25:0] w_limit;
        w_limit = {1'b0, base} + {1'b0, size};
        if (e < base)
            return PSEL_1;
        else if ({1'b0, e} < w_limit)
            return PSEL_2;
        else
            return PSEL_NONE;
    endfunction

    function automatic logic [22:0] word_addr(input logic [24:0] e, input psel_t sel,
                                              input logic [24:0] base);
        logic [24:0] w_off;
        w_off = (sel == PSEL_2) ? (e - base) : e;
        return 23'(w_off >> 1);
    endfunction

endpackage

// File: rtl/loader_toggle_port.sv
// rtl/loader_toggle_port.sv - one controller port: toggle request, ack compare and write-word registers
module loader_toggle_port (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_issue,
    input  logic [22:0] i_a,
    input  logic [1:0]  i_ds,
    input  logic [15:0] i_d,
    input  logic        i_ack,
    output logic        o_req,
    output logic        o_busy,
    output logic [22:0] o_a,
    output logic [1:0]  o_ds,
    output logic [15:0] o_d
);

    logic        r_req;
    logic [22:0] r_a;
    logic [1:0]  r_ds;
    logic [15:0] r_d;

    // Reset copies ack into req so any write in flight is simply forgotten.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req <= i_ack;
            r_a   <= '0;
            r_ds  <= '0;
            r_d   <= '0;
        end else if (i_issue) begin
            r_req <= ~r_req;
            r_a   <= i_a;
            r_ds  <= i_ds;
            r_d   <= i_d;
        end
    end

    assign o_req  = r_req;
    assign o_busy = (r_req != i_ack);
    assign o_a    = r_a;
    assign o_ds   = r_ds;
    assign o_d    = r_d;

endmodule

// File: rtl/sdram_rom_loader.sv
// rtl/sdram_rom_loader.sv - packs ioctl download bytes into masked 16-bit SDRAM writes on two ports
module sdram_rom_loader #(
    parameter logic [24:0] PORT2_BASE = 25'h0100000,
    parameter logic [24:0] PORT2_SIZE = 25'h0100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic        port1_we,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic [15:0] port1_d,
    output logic        port2_req,
    input  logic        port2_ack,
    output logic        port2_we,
    output logic [22:0] port2_a,
    output logic [1:0]  port2_ds,
    output logic [15:0] port2_d,
    output logic        load_done
);
    import sdram_loader_pkg::*;

    state_t      r_state, w_state_nxt;
    logic [24:0] r_held_addr, w_held_addr_nxt;
    logic [7:0]  r_held_data, w_held_data_nxt;
    logic        r_skid_valid, w_skid_valid_nxt;
    logic [24:0] r_skid_addr, w_skid_addr_nxt;
    logic [7:0]  r_skid_data, w_skid_data_nxt;
    psel_t       r_psel, w_psel_nxt;
    logic [22:0] r_word_a, w_word_a_nxt;
    logic [1:0]  r_word_ds, w_word_ds_nxt;
    logic [15:0] r_word_d, w_word_d_nxt;
    logic        r_dl_prev;
    logic        r_end_pending, w_end_pending_nxt;
    logic        r_wait;
    logic        r_load_done;

    logic        w_wr, w_dl_fall, w_end;
    logic        w_take, w_issue, w_issue1, w_issue2;
    logic        w_busy1, w_busy2, w_busy;
    logic        w_merge;
    logic [24:0] w_cand_addr, w_cand_even;
    logic [7:0]  w_cand_data;
    psel_t       w_cand_sel, w_held_sel;
    logic [22:0] w_cand_wa, w_held_wa;

    assign w_wr      = ioctl_wr & ioctl_download;
    assign w_dl_fall = r_dl_prev & ~ioctl_download;
    assign w_end     = r_end_pending | w_dl_fall;
    assign w_merge   = (ioctl_addr == r_held_addr + 25'd1);

    // After an ack the skid byte is older than anything on the bus, so it is consumed first.
    always_comb begin
        w_cand_addr = ioctl_addr;
        w_cand_data = ioctl_dout;
        if (r_state == WAIT_ACK && r_skid_valid) begin
            w_cand_addr = r_skid_addr;
            w_cand_data = r_skid_data;
        end
    end

    assign w_cand_even = {w_cand_addr[24:1], 1'b0};
    assign w_cand_sel  = route_sel(w_cand_even, PORT2_BASE, PORT2_SIZE);
    assign w_cand_wa   = word_addr(w_cand_even, w_cand_sel, PORT2_BASE);
    assign w_held_sel  = route_sel(r_held_addr, PORT2_BASE, PORT2_SIZE);
    assign w_held_wa   = word_addr(r_held_addr, w_held_sel, PORT2_BASE);

    assign w_busy = (r_psel == PSEL_1) ? w_busy1 :
                    (r_psel == PSEL_2) ? w_busy2 : 1'b0;

    always_comb begin
        w_state_nxt      = r_state;
        w_held_addr_nxt  = r_held_addr;
        w_held_data_nxt  = r_held_data;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_addr_nxt  = r_skid_addr;
        w_skid_data_nxt  = r_skid_data;
        w_psel_nxt       = r_psel;
        w_word_a_nxt     = r_word_a;
        w_word_ds_nxt    = r_word_ds;
        w_word_d_nxt     = r_word_d;
        w_take           = 1'b0;
        w_issue          = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_wr)
                    w_take = 1'b1;
                else if (w_end)
                    w_state_nxt = DONE;
            end
            HOLD: begin
                if (w_wr || w_end) begin
                    w_state_nxt   = ISSUE;
                    w_psel_nxt    = w_held_sel;
                    w_word_a_nxt  = w_held_wa;
                    w_word_ds_nxt = DS_LO;
                    w_word_d_nxt  = {8'h00, r_held_data};
                    if (w_wr && w_merge) begin
                        w_word_ds_nxt = DS_BOTH;
                        w_word_d_nxt  = {ioctl_dout, r_held_data};
                    end else if (w_wr) begin
                        w_skid_valid_nxt = 1'b1;
                        w_skid_addr_nxt  = ioctl_addr;
                        w_skid_data_nxt  = ioctl_dout;
                    end
                end
            end
            ISSUE: begin
                w_issue     = 1'b1;
                w_state_nxt = WAIT_ACK;
                if (w_wr) begin
                    w_skid_valid_nxt = 1'b1;
                    w_skid_addr_nxt  = ioctl_addr;
                    w_skid_data_nxt  = ioctl_dout;
                end
            end
            WAIT_ACK: begin
                if (!w_busy) begin
                    if (r_skid_valid || w_wr) begin
                        w_take           = 1'b1;
                        w_skid_valid_nxt = r_skid_valid && w_wr;
                        if (r_skid_valid && w_wr) begin
                            w_skid_addr_nxt = ioctl_addr;
                            w_skid_data_nxt = ioctl_dout;
                        end
                    end else if (w_end) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_wr) begin
                    w_skid_valid_nxt = 1'b1;
                    w_skid_addr_nxt  = ioctl_addr;
                    w_skid_data_nxt  = ioctl_dout;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // A byte taken as if in IDLE: out-of-range bytes vanish, even bytes wait for a partner.
        if (w_take) begin
            w_state_nxt = IDLE;
            if (w_cand_sel != PSEL_NONE) begin
                if (!w_cand_addr[0]) begin
                    w_state_nxt     = HOLD;
                    w_held_addr_nxt = w_cand_addr;
                    w_held_data_nxt = w_cand_data;
                end else begin
                    w_state_nxt   = ISSUE;
                    w_psel_nxt    = w_cand_sel;
                    w_word_a_nxt  = w_cand_wa;
                    w_word_ds_nxt = DS_HI;
                    w_word_d_nxt  = {w_cand_data, 8'h00};
                end
            end
        end
    end

    always_comb begin
        w_end_pending_nxt = r_end_pending | w_dl_fall;
        if (ioctl_download || w_state_nxt == DONE)
            w_end_pending_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_held_addr   <= '0;
            r_held_data   <= '0;
            r_skid_valid  <= 1'b0;
            r_skid_addr   <= '0;
            r_skid_data   <= '0;
            r_psel        <= PSEL_NONE;
            r_word_a      <= '0;
            r_word_ds     <= '0;
            r_word_d      <= '0;
            r_dl_prev     <= 1'b0;
            r_end_pending <= 1'b0;
            r_wait        <= 1'b0;
            r_load_done   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_held_addr   <= w_held_addr_nxt;
            r_held_data   <= w_held_data_nxt;
            r_skid_valid  <= w_skid_valid_nxt;
            r_skid_addr   <= w_skid_addr_nxt;
            r_skid_data   <= w_skid_data_nxt;
            r_psel        <= w_psel_nxt;
            r_word_a      <= w_word_a_nxt;
            r_word_ds     <= w_word_ds_nxt;
            r_word_d      <= w_word_d_nxt;
            r_dl_prev     <= ioctl_download;
            r_end_pending <= w_end_pending_nxt;
            r_wait        <= (w_state_nxt == ISSUE) || (w_state_nxt == WAIT_ACK) || w_skid_valid_nxt;
            r_load_done   <= (w_state_nxt == DONE);
        end
    end

    assign w_issue1 = w_issue && (r_psel == PSEL_1);
    assign w_issue2 = w_issue && (r_psel == PSEL_2);

    loader_toggle_port u_port1 (
        .clk     (clk),
        .reset   (reset),
        .i_issue (w_issue1),
        .i_a     (r_word_a),
        .i_ds    (r_word_ds),
        .i_d     (r_word_d),
        .i_ack   (port1_ack),
        .o_req   (port1_req),
        .o_busy  (w_busy1),
        .o_a     (port1_a),
        .o_ds    (port1_ds),
        .o_d     (port1_d)
    );

    loader_toggle_port u_port2 (
        .clk     (clk),
        .reset   (reset),
        .i_issue (w_issue2),
        .i_a     (r_word_a),
        .i_ds    (r_word_ds),
        .i_d     (r_word_d),
        .i_ack   (port2_ack),
        .o_req   (port2_req),
        .o_busy  (w_busy2),
        .o_a     (port2_a),
        .o_ds    (port2_ds),
        .o_d     (port2_d)
    );

    assign port1_we   = 1'b1;
    assign port2_we   = 1'b1;
    assign ioctl_wait = r_wait;
    assign load_done  = r_load_done;

endmodule

// File: tb/tb_sdram_rom_loader.sv
// tb/tb_sdram_rom_loader.sv - scoreboard bench for sdram_rom_loader with directed and random downloads
module tb_sdram_rom_loader;

    localparam logic [24:0] P2B = 25'h0100000;
    localparam logic [24:0] P2S = 25'h0100000;

    logic        clk;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        port1_req, port1_ack, port1_we;
    logic [22:0] port1_a;
    logic [1:0]  port1_ds;
    logic [15:0] port1_d;
    logic        port2_req, port2_ack, port2_we;
    logic [22:0] port2_a;
    logic [1:0]  port2_ds;
    logic [15:0] port2_d;
    logic        load_done;

    sdram_rom_loader #(.PORT2_BASE(P2B), .PORT2_SIZE(P2S)) dut (
        .clk            (clk),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .port1_req      (port1_req),
        .port1_ack      (port1_ack),
        .port1_we       (port1_we),
        .port1_a        (port1_a),
        .port1_ds       (port1_ds),
        .port1_d        (port1_d),
        .port2_req      (port2_req),
        .port2_ack      (port2_ack),
        .port2_we       (port2_we),
        .port2_a        (port2_a),
        .port2_ds       (port2_ds),
        .port2_d        (port2_d),
        .load_done      (load_done)
    );

    typedef struct packed {
        logic [1:0]  port;
        logic [22:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   writes_seen = 0;
    int   done_cnt = 0;
    bit   ack_hold = 0;
    bit   ack_rand = 0;
    int   ack_delay = 2;
    bit   model_on = 0;
    logic rst_q = 1'b1;

    bit          m_held = 0;
    logic [24:0] m_haddr;
    logic [7:0]  m_hdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int port, input logic [22:0] a, input logic [1:0] ds,
                            input logic [15:0] d);
        exp_t e;
        e.port = 2'(port);
        e.a    = a;
        e.ds   = ds;
        e.d    = d;
        exp_q.push_back(e);
    endtask

    // Reference model: byte-stream rules applied in order, no timing.
    function automatic int region(input logic [24:0] e);
        if (int'(e) < int'(P2B)) return 1;
        if (int'(e) < int'(P2B) + int'(P2S)) return 2;
        return 0;
    endfunction

    task automatic model_emit(input logic [24:0] e, input logic [1:0] ds, input logic [15:0] d);
        int r;
        logic [24:0] off;
        r = region(e);
        off = (r == 2) ? e - P2B : e;
        push_exp(r, 23'(off / 2), ds, d);
    endtask

    task automatic model_byte(input logic [24:0] addr, input logic [7:0] data);
        logic [24:0] e;
        if (m_held) begin
            m_held = 0;
            if (addr == m_haddr + 25'd1) begin
                model_emit(m_haddr, 2'b11, {data, m_hdata});
                return;
            end
            model_emit(m_haddr, 2'b01, {8'h00, m_hdata});
        end
        e = addr & ~25'd1;
        if (region(e) == 0) return;
        if (addr[0] == 1'b0) begin
            m_held  = 1;
            m_haddr = addr;
            m_hdata = data;
        end else begin
            model_emit(e, 2'b10, {data, 8'h00});
        end
    endtask

    task automatic model_flush();
        if (m_held) model_emit(m_haddr, 2'b01, {8'h00, m_hdata});
        m_held = 0;
    endtask

    task automatic pulse_wr(input logic [24:0] addr, input logic [7:0] data);
        ioctl_addr = addr;
        ioctl_dout = data;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic send_byte(input logic [24:0] addr, input logic [7:0] data);
        int n = 0;
        while (ioctl_wait && n < 1000) begin
            tick();
            n++;
        end
        if (ioctl_wait) check("send_wait_timeout", 1, 0);
        if (model_on) model_byte(addr, data);
        pulse_wr(addr, data);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || port1_req !== port1_ack || port2_req !== port2_ack) && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) check({name, "_idle_timeout"}, 1, 0);
        repeat (2) tick();
    endtask

    task automatic end_download(input string name);
        int d0 = done_cnt;
        int n = 0;
        if (model_on) model_flush();
        ioctl_download = 1'b0;
        while (done_cnt == d0 && n < 2000) begin
            tick();
            n++;
        end
        repeat (5) tick();
        check({name, "_load_done_once"}, 32'(done_cnt - d0), 1);
    endtask

    function automatic logic [24:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return 25'($urandom_range(0, 127));
            1:       return P2B + 25'($urandom_range(0, 127));
            2:       return P2B + P2S - 25'($urandom_range(1, 8));
            default: return P2B + P2S + 25'($urandom_range(0, 8));
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        rst_q = reset;
    end

    initial begin : resp1
        int cnt = 0;
        int dly = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!ack_hold && !reset && port1_req !== port1_ack) begin
                if (cnt == 0) dly = ack_rand ? int'($urandom_range(0, 5)) : ack_delay;
                if (cnt >= dly) begin
                    port1_ack = port1_req;
                    cnt = 0;
                end else cnt++;
            end else cnt = 0;
        end
    end

    initial begin : resp2
        int cnt = 0;
        int dly = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!ack_hold && !reset && port2_req !== port2_ack) begin
                if (cnt == 0) dly = ack_rand ? int'($urandom_range(0, 5)) : ack_delay;
                if (cnt >= dly) begin
                    port2_ack = port2_req;
                    cnt = 0;
                end else cnt++;
            end else cnt = 0;
        end
    end

    task automatic check_write(input int port);
        exp_t e;
        logic [22:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
        writes_seen++;
        a  = (port == 1) ? port1_a : port2_a;
        ds = (port == 1) ? port1_ds : port2_ds;
        d  = (port == 1) ? port1_d : port2_d;
        check("one_outstanding", (port == 1) ? 32'(port2_req ^ port2_ack) : 32'(port1_req ^ port1_ack), 0);
        if (exp_q.size() == 0) begin
            check("unexpected_write_port", 32'(port), 0);
        end else begin
            e = exp_q.pop_front();
            check("write_port", 32'(port), 32'(e.port));
            check("write_a", 32'(a), 32'(e.a));
            check("write_ds", 32'(ds), 32'(e.ds));
            check("write_d", 32'(d & {{8{e.ds[1]}}, {8{e.ds[0]}}}), 32'(e.d));
        end
    endtask

    initial begin : monitor
        logic p1, p2;
        p1 = 1'b0;
        p2 = 1'b0;
        forever begin
            @(negedge clk);
            if (reset || rst_q) begin
                p1 = port1_req;
                p2 = port2_req;
            end else begin
                if (port1_req !== p1 && port2_req !== p2) check("dual_issue", 1, 0);
                if (port1_req !== p1) check_write(1);
                else if (port2_req !== p2) check_write(2);
                p1 = port1_req;
                p2 = port2_req;
                if (load_done) begin
                    done_cnt++;
                    check("done_queue_empty", 32'(exp_q.size()), 0);
                    check("done_all_acked", {30'd0, port1_req ^ port1_ack, port2_req ^ port2_ack}, 0);
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin : stim
        int w0, n, low_seen, d0;
        logic [24:0] cur;
        reset = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        port1_ack = 1'b0;
        port2_ack = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_port1_req", 32'(port1_req), 0);
        check("rst_port2_req", 32'(port2_req), 1);
        check("rst_wait", 32'(ioctl_wait), 0);
        check("rst_load_done", 32'(load_done), 0);
        check("rst_port1_word", {port1_a, port1_ds, 7'd0}, 0);
        check("rst_port1_d", 32'(port1_d), 0);
        check("rst_port2_word", {port2_a, port2_ds, 7'd0}, 0);
        check("rst_we", {30'd0, port1_we, port2_we}, 3);
        tick();
        reset = 1'b0;
        tick();

        ioctl_download = 1'b1;
        tick();
        push_exp(1, 23'd0, 2'b11, 16'h2211);
        send_byte(25'd0, 8'h11);
        send_byte(25'd1, 8'h22);
        wait_idle("t1");
        check("t1_wait_low", 32'(ioctl_wait), 0);

        push_exp(2, 23'h2, 2'b11, 16'hBBAA);
        send_byte(P2B + 25'd4, 8'hAA);
        send_byte(P2B + 25'd5, 8'hBB);
        wait_idle("t2");

        push_exp(1, 23'd3, 2'b01, 16'h0055);
        push_exp(1, 23'd4, 2'b10, 16'h6600);
        send_byte(25'd6, 8'h55);
        send_byte(25'd9, 8'h66);
        wait_idle("t3");

        push_exp(1, 23'd5, 2'b01, 16'h0077);
        send_byte(25'd10, 8'h77);
        end_download("t4");

        ioctl_download = 1'b1;
        tick();
        ack_delay = 20;
        push_exp(1, 23'd10, 2'b11, 16'hC2C1);
        push_exp(1, 23'd11, 2'b10, 16'hC300);
        w0 = writes_seen;
        pulse_wr(25'd20, 8'hC1);
        pulse_wr(25'd21, 8'hC2);
        pulse_wr(25'd23, 8'hC3);
        low_seen = 0;
        n = 0;
        while (writes_seen < w0 + 2 && n < 300) begin
            @(negedge clk);
            if (!ioctl_wait) low_seen = 1;
            n++;
        end
        check("t5_wait_held", 32'(low_seen), 0);
        check("t5_writes", 32'(writes_seen - w0), 2);
        tick();
        wait_idle("t5");
        ack_delay = 2;
        end_download("t5");

        ioctl_download = 1'b1;
        tick();
        ack_hold = 1;
        push_exp(1, 23'd15, 2'b11, 16'h0201);
        w0 = writes_seen;
        pulse_wr(25'd30, 8'h01);
        pulse_wr(25'd31, 8'h02);
        n = 0;
        while (writes_seen == w0 && n < 50) begin
            tick();
            n++;
        end
        check("t6_issued", 32'(writes_seen - w0), 1);
        repeat (2) tick();
        d0 = done_cnt;
        reset = 1'b1;
        tick();
        port1_ack = ~port1_ack;
        repeat (2) tick();
        reset = 1'b0;
        ack_hold = 0;
        @(negedge clk);
        check("t6_req_eq_ack", 32'(port1_req ^ port1_ack), 0);
        check("t6_wait_low", 32'(ioctl_wait), 0);
        check("t6_ds_cleared", 32'(port1_ds), 0);
        tick();
        pulse_wr(P2B + P2S, 8'h5A);
        repeat (6) tick();
        check("t6_oob_no_write", 32'(writes_seen - w0), 1);
        check("t6_oob_wait_low", 32'(ioctl_wait), 0);
        check("t6_no_done", 32'(done_cnt - d0), 0);
        push_exp(2, 23'h7FFFF, 2'b10, 16'hE700);
        send_byte(P2B + P2S - 25'd1, 8'hE7);
        wait_idle("t6");
        end_download("t6");

        w0 = writes_seen;
        d0 = done_cnt;
        pulse_wr(25'h40, 8'h99);
        repeat (8) tick();
        check("t7_idle_wr_ignored", 32'(writes_seen - w0), 0);
        check("t7_no_done", 32'(done_cnt - d0), 0);

        model_on = 1;
        ack_rand = 1;
        for (int dl = 0; dl < 3; dl++) begin
            ioctl_download = 1'b1;
            tick();
            cur = pick_addr();
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(0, 9) < 7) cur = cur + 25'd1;
                else cur = pick_addr();
                send_byte(cur, 8'($urandom));
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
            end
            end_download("rand");
            wait_idle("rand");
        end
        check("final_queue_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_rom_loader.md
Name: sdram_rom_loader

Overview:
Upstream feeder for the dual-port SDRAM controller during ROM download. Takes the byte stream from the HPS download interface (ioctl_*), packs byte pairs into 16-bit words with byte masks, and routes each word to controller port 1 (banks 0/1) or port 2 (banks 2/3) by address region. Uses the controller's toggle req/ack handshake and back-pressures the download source through ioctl_wait.

Parameters:
PORT2_BASE, 25'h0100000, first byte address routed to port 2 (must be even)
PORT2_SIZE, 25'h0100000, byte size of the port 2 region; bytes at or above PORT2_BASE+PORT2_SIZE are dropped

Ports:
clk  in  1  SDRAM clock, same clock as the controller
reset  in  1  synchronous, active-high reset
ioctl_download  in  1  high for the whole download
ioctl_wr  in  1  single-cycle byte strobe
ioctl_addr  in  25  byte address
ioctl_dout  in  8  byte data
ioctl_wait  out  1  stall request to the download source
port1_req / port2_req  out  1  toggle request to the controller
port1_ack / port2_ack  in  1  toggle acknowledge; equals req when done
port1_we / port2_we  out  1  tied high (writes only)
port1_a / port2_a  out  23  word address [23:1]
port1_ds / port2_ds  out  2  byte mask {hi,lo}
port1_d / port2_d  out  16  write data
load_done  out  1  one-cycle pulse after the last write of a download is acknowledged

Behaviour:
- One clock and one reset. reset is synchronous and active-high, and the ports are named clk and reset.
- Reset values:
  - portN_req <= portN_ack (resynchronise; no write outstanding).
  - a, ds, d <= 0.
  - ioctl_wait <= 0, load_done <= 0.
  - Held byte and skid register are cleared. FSM goes to IDLE.
- Reset in the middle of a write abandons it. No flush is issued.
- Byte lanes:
  - Even address: byte goes to d[7:0], ds=2'b01.
  - Odd address: byte goes to d[15:8], ds=2'b10.
  - A merged pair uses ds=2'b11.
- Routing, evaluated on the word's even byte address E:
  - E < PORT2_BASE: port 1, a=E[23:1].
  - PORT2_BASE <= E < PORT2_BASE+PORT2_SIZE: port 2, a=(E-PORT2_BASE)[23:1]. Subtraction is 25-bit, then truncated.
  - Otherwise the byte is discarded with no handshake and no wait.
- FSM states: IDLE, HOLD, ISSUE, WAIT_ACK, DONE.
  - IDLE:
    - Even byte in range: latch it as held byte, go to HOLD.
    - Odd byte: build a single-byte word, go to ISSUE.
  - HOLD:
    - Odd byte at held address+1: merge (ds=11), go to ISSUE.
    - Any other byte: issue the held byte alone (ds=01). The new byte goes into the skid register.
    - Falling ioctl_download: flush the held byte alone.
  - ISSUE: drive a/ds/d, toggle the selected portN_req, go to WAIT_ACK. The other port's req is untouched.
  - WAIT_ACK: hold a/ds/d stable. When portN_ack==portN_req:
    - If the skid register is valid, process it as if arriving in IDLE.
    - Else if the download is over and nothing is held, go to DONE.
    - Else go to IDLE.
  - DONE: pulse load_done for one cycle, go to IDLE.
- Latency: the req toggle occurs on the clock edge after the ioctl_wr that completes a word (or the edge after download falls, for a flush).
- ioctl_wait:
  - High while in ISSUE, WAIT_ACK, or while the skid register is valid.
  - Low in IDLE/HOLD.
  - Registered, so it rises one cycle after the triggering wr.
- Skid register: absorbs exactly one byte that arrives in the same cycle ioctl_wait rises. A second byte while the skid is valid is a source protocol violation; the skid is overwritten.
- Only one write is outstanding across both ports at any time.
- ioctl_wr while ioctl_download is low is ignored.
- A download that ends with nothing held and nothing outstanding goes straight to DONE.

Decomposition:
- Package sdram_loader_pkg:
  - state enum (IDLE, HOLD, ISSUE, WAIT_ACK, DONE)
  - port-select enum (PSEL_NONE, PSEL_1, PSEL_2)
  - ds constants DS_LO=2'b01, DS_HI=2'b10, DS_BOTH=2'b11
- One natural sub-module, loader_toggle_port: per-port req toggle register, ack compare, and a/ds/d output registers. Instantiated twice.

Test Plan:
- Download bytes 0x11@0, 0x22@1 -> one port1 write: a=0, d=16'h2211, ds=11, req toggles once; after ack, ioctl_wait drops.
- Bytes 0xAA@PORT2_BASE+4, 0xBB@PORT2_BASE+5 -> port2 write: a=23'h2, d=16'hBBAA, ds=11; port1_req unchanged.
- Byte 0x55@6, then 0x66@9 -> port1 write a=3, d[7:0]=55, ds=01; then a=4, d[15:8]=66, ds=10.
- Byte 0x77@10, then download falls -> flush a=5, ds=01; load_done pulses exactly once, one cycle after ack.
- Ack delayed 20 cycles with a byte arriving on the wait-rise cycle -> the skid byte is written after the first ack; no byte is lost; ioctl_wait stays high throughout.
- reset asserted during WAIT_ACK, with portN_ack then toggling -> after reset req==ack, no further writes, ioctl_wait=0; a byte at PORT2_BASE+PORT2_SIZE produces no req toggle.
